// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encodings, frame header byte,
// and the word-address helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] BOOT_HDR = 8'hA5;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, RAM write port and core-hold status of the boot loader.
// master = byte source / RAM side, slave = the loader itself.
interface boot_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/boot_loader_byte_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words; o_word_valid pulses
// for one cycle with o_word once the fourth byte of a word has been taken.
module boot_loader_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_lane,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane       <= 2'd0;
      r_shift      <= 24'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_lane  <= 2'd0;
        r_shift <= 24'd0;
      end else if (i_byte_valid) begin
        r_lane <= r_lane + 2'd1;
        // bytes enter at the top and slide down, so byte 0 ends in bits [7:0]
        if (r_lane == 2'd3) begin
          r_word       <= {i_byte, r_shift};
          r_word_valid <= 1'b1;
        end else begin
          r_shift <= {i_byte, r_shift[23:8]};
        end
      end
    end
  end

  assign o_lane       = r_lane;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/boot_loader.sv
// Frame-driven program loader: header, word count, payload words written to RAM, checksum.
// Optional checksum enforcement with BOOT_LOADER_CSUM_EN; without it the checksum byte is ignored.
//
// state | meaning
// IDLE  | after reset, discarding bytes until the header
// LEN   | collecting 4-byte word count, LSB first
// DATA  | collecting payload, one RAM write per 4 bytes
// CSUM  | waiting for the checksum byte
// DONE  | image loaded, core released
// ERR   | frame rejected, core held; header restarts
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          TIMEOUT_CYC = 100000
) (
  input logic          i_clk,
  input logic          i_rst,
  boot_loader_if.slave bus
);

  localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_TC   = TW'(1);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_t        r_state;
  logic [1:0]    r_len_cnt;
  logic [23:0]   r_len;
  logic [31:0]   r_words_left;
  logic [31:0]   r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_in_ready;
  logic [31:0]   r_mem_addr;
  logic          r_cpu_hold;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_restart;
  logic          w_in_frame;
  logic          w_pk_valid;
  logic          w_word_last;
  logic          w_csum_ok;
  logic [31:0]   w_len_full;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic          w_word_valid;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_in_frame  = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign w_restart   = w_accept && (bus.in_data == BOOT_HDR) &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_pk_valid  = w_accept && (r_state == ST_DATA);
  assign w_word_last = w_pk_valid && (w_lane == 2'd3);
  assign w_len_full  = {bus.in_data, r_len};

  boot_loader_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_restart),
    .i_byte_valid (w_pk_valid),
    .i_byte       (bus.in_data),
    .o_lane       (w_lane),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_restart) begin
      r_csum <= 8'd0;
    end else if (w_pk_valid) begin
      r_csum <= r_csum + bus.in_data;
    end
  end

  assign w_csum_ok = (r_csum == bus.in_data);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_len_cnt    <= 2'd0;
      r_len        <= 24'd0;
      r_words_left <= 32'd0;
      r_idx        <= 32'd0;
      r_tmo        <= '0;
      r_in_ready   <= 1'b0;
      r_mem_addr   <= BASE_ADDR;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // stall the source for the cycle the completed word is on the RAM port
      r_in_ready <= ~w_word_last;

      if (w_accept) begin
        r_tmo <= TMO_LOAD;
      end else if (w_in_frame) begin
        r_tmo <= r_tmo - TMO_TC;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_restart) begin
            r_state    <= ST_LEN;
            r_len_cnt  <= 2'd0;
            r_idx      <= 32'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            r_len     <= w_len_full[31:8];
            r_len_cnt <= r_len_cnt + 2'd1;
            if (r_len_cnt == 2'd3) begin
              if (w_len_full > DEPTH_LIM) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end else if (w_len_full == 32'd0) begin
                r_state <= ST_CSUM;
              end else begin
                r_state      <= ST_DATA;
                r_words_left <= w_len_full;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_word_last) begin
            r_mem_addr   <= word_addr(BASE_ADDR, r_idx);
            r_idx        <= r_idx + 32'd1;
            r_words_left <= r_words_left - 32'd1;
            if (r_words_left == 32'd1) begin
              r_state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            if (w_csum_ok) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_in_frame && !w_accept && (r_tmo == TMO_TC)) begin
        r_state <= ST_ERR;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = w_word_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = w_word;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected RAM writes are queued as frames are sent and
// checked by an independent monitor; status flags are checked after each frame.
module tb_boot_loader;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int          TB_DEPTH = 1024;
  localparam int          TB_TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if bus ();

  boot_loader #(
    .BASE_ADDR   (TB_BASE),
    .DEPTH_WORDS (TB_DEPTH),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      chk("ready_low_on_we", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", bus.mem_addr, mon_e[63:32]);
        chk("write_data", bus.mem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_tot++;
      $display("FAIL accept_wait: byte %h not accepted in 20 cycles", b);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    send_byte(n[23:16]);
    send_byte(n[31:24]);
  endtask

  task automatic send_words(input logic [31:0] w[$]);
    foreach (w[i]) begin
      send_byte(w[i][7:0]);
      send_byte(w[i][15:8]);
      send_byte(w[i][23:16]);
      send_byte(w[i][31:24]);
    end
  endtask

  task automatic push_writes(input logic [31:0] w[$]);
    foreach (w[i]) exp_q.push_back({TB_BASE + 32'(4 * i), w[i]});
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] w[$]);
    logic [7:0] s = 8'd0;
    foreach (w[i]) s = s + w[i][7:0] + w[i][15:8] + w[i][23:16] + w[i][31:24];
    return s;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tot++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: %0d expected writes never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_status(input string name, input logic done, input logic err, input logic hold);
    @(negedge clk);
    chk({name, "_done"}, 32'(bus.load_done), 32'(done));
    chk({name, "_err"},  32'(bus.load_err),  32'(err));
    chk({name, "_hold"}, 32'(bus.cpu_hold),  32'(hold));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, 32'(bus.in_ready),  32'd0);
    chk({name, "_mem_we"},   32'(bus.mem_we),    32'd0);
    chk({name, "_mem_addr"}, bus.mem_addr,       TB_BASE);
    chk({name, "_wdata"},    bus.mem_wdata,      32'd0);
    chk({name, "_hold"},     32'(bus.cpu_hold),  32'd1);
    chk({name, "_done"},     32'(bus.load_done), 32'd0);
    chk({name, "_err"},      32'(bus.load_err),  32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(name);
    rst = 1'b0;
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    do_reset("reset");

    // good two-word image
    img = {32'h0000_0013, 32'h0010_0093};
    push_writes(img);
    send_byte(8'hA5);
    send_len(32'd2);
    send_words(img);
    send_byte(csum_of(img));
    drain("t1_writes");
    chk_status("t1", 1'b1, 1'b0, 1'b0);

    // same image with wrong checksum, restarted straight from DONE
    push_writes(img);
    send_byte(8'hA5);
    chk_status("t2_restart", 1'b0, 1'b0, 1'b1);
    send_len(32'd2);
    send_words(img);
    send_byte(8'h00);
    drain("t2_writes");
`ifdef BOOT_LOADER_CSUM_EN
    chk_status("t2", 1'b0, 1'b1, 1'b1);
`else
    chk_status("t2", 1'b1, 1'b0, 1'b0);
`endif

    // one word over the limit: error on the last length byte
    send_byte(8'hA5);
    send_len(32'(TB_DEPTH + 1));
    chk_status("t3_over", 1'b0, 1'b1, 1'b1);
    repeat (10) @(posedge clk);

    // exactly at the limit is accepted; abandoned frame then times out
    send_byte(8'hA5);
    send_len(32'(TB_DEPTH));
    chk_status("t3_limit", 1'b0, 1'b0, 1'b1);
    repeat (TB_TMO + 4) @(posedge clk);
    chk_status("t3_limit_tmo", 1'b0, 1'b1, 1'b1);

    // timeout boundary after a partial word
    send_byte(8'hA5);
    send_len(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TB_TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("t4_err_before_tc", 32'(bus.load_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_err_at_tc", 32'(bus.load_err), 32'd1);
    chk("t4_hold", 32'(bus.cpu_hold), 32'd1);

    // garbage in IDLE, then empty image
    do_reset("t5_reset");
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk_status("t5_garbage", 1'b0, 1'b0, 1'b1);
    send_byte(8'hA5);
    send_len(32'd0);
    send_byte(8'h00);
    chk_status("t5", 1'b1, 1'b0, 1'b0);

    // reset in the middle of a four-word frame
    img = {32'hDEAD_BEEF, 32'h0102_0304};
    push_writes(img);
    send_byte(8'hA5);
    send_len(32'd4);
    send_words(img);
    drain("t6_writes");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    img = {32'h1234_5678};
    push_writes(img);
    send_byte(8'hA5);
    send_len(32'd1);
    send_words(img);
    send_byte(csum_of(img));
    drain("t6_reload");
    chk_status("t6", 1'b1, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
